// File: rtl/arf_stream_source_pkg.sv
// Shared constants and helpers for the arf stream bridges (source now, sink later).
package arf_stream_source_pkg;

  localparam int unsigned HS_COUNT_WIDTH = 32;

  // Occupancy counter width: must hold the value depth itself, not just depth-1.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output and a separate occupancy counter.
module sync_fifo
  import arf_stream_source_pkg::*;
#(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [data_width-1:0]           wr_data,
  input  logic                            rd_en,
  output logic [data_width-1:0]           rd_data,
  output logic [level_width(depth)-1:0]   level,
  output logic                            full,
  output logic                            empty
);

  localparam int unsigned PtrW   = $clog2(depth);
  localparam int unsigned LevelW = level_width(depth);

  logic [data_width-1:0] mem_q [depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0]     level_q;
  logic                  push, pop;

  assign full    = (level_q == LevelW'(depth));
  assign empty   = (level_q == '0);
  // A full FIFO refuses writes even when a read happens on the same edge.
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/arf_stream_source.sv
// Bridges a valid/ready stream into an arf dataflow input: level req in, one-cycle ack + data out.
module arf_stream_source
  import arf_stream_source_pkg::*;
#(
  parameter int unsigned          data_width    = 32,
  parameter int unsigned          depth         = 4,
  parameter logic [data_width-1:0] initial_value = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [data_width-1:0]         s_data,
  input  logic                          req,
  output logic                          ack,
  output logic [data_width-1:0]         dout,
  output logic [HS_COUNT_WIDTH-1:0]     count,
  output logic [level_width(depth)-1:0] level
);

  logic                      full, empty;
  logic                      wr_en, pop;
  logic [data_width-1:0]     head;
  logic                      ack_q;
  logic [data_width-1:0]     dout_q;
  logic [HS_COUNT_WIDTH-1:0] count_q;

  assign s_ready = ~rst & ~full;
  assign wr_en   = s_valid & s_ready;
  // Blocking on ack_q keeps one pop per request: the requester drops req a cycle after ack.
  assign pop     = req & ~ack_q & ~empty;

  sync_fifo #(
    .data_width(data_width),
    .depth     (depth)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(s_data),
    .rd_en  (pop),
    .rd_data(head),
    .level  (level),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      dout_q  <= initial_value;
      count_q <= '0;
    end else begin
      ack_q <= pop;
      if (pop) begin
        dout_q  <= head;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign ack   = ack_q;
  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: tb/tb_arf_stream_source.sv
// Scoreboard bench for arf_stream_source: words queued on accept, checked on each ack.
module tb_arf_stream_source;

  localparam int unsigned    DW    = 32;
  localparam int unsigned    DEPTH = 4;
  localparam logic [DW-1:0]  INIT  = 32'hCAFE_0001;

  logic          clk = 1'b0;
  logic          rst, s_valid, s_ready, req, ack;
  logic [DW-1:0] s_data, dout;
  logic [31:0]   count;
  logic [2:0]    level;

  always #5 clk = ~clk;

  arf_stream_source #(
    .data_width   (DW),
    .depth        (DEPTH),
    .initial_value(INIT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .req    (req),
    .ack    (ack),
    .dout   (dout),
    .count  (count),
    .level  (level)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  int            m_level = 0;
  logic          m_ack = 1'b0;
  logic [31:0]   m_count = '0;
  logic [DW-1:0] m_dout = INIT;

  // Advance one clock; the behavioural model tracks occupancy, ack and count from the inputs.
  task automatic cycle();
    bit push, pop;
    push = !rst && s_valid && (m_level != DEPTH);
    pop  = !rst && req && !m_ack && (m_level != 0);
    @(posedge clk);
    if (rst) begin
      m_level = 0; m_ack = 1'b0; m_count = '0; m_dout = INIT;
      exp_q.delete();
    end else begin
      if (push) exp_q.push_back(s_data);
      m_level = m_level + (push ? 1 : 0) - (pop ? 1 : 0);
      m_ack   = pop;
      if (pop) m_count = m_count + 1;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; s_valid = 1'b0; req = 1'b0; s_data = '0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] e;
    rst = 1'b1; s_valid = 1'b1; s_data = 32'h7; req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_vec++;
      if (ack !== 1'b0 || s_ready !== 1'b0 || dout !== INIT || count !== 32'd0 || level !== 3'd0) begin
        n_err++;
        $display("FAIL reset_state: ack=%b s_ready=%b dout=%h count=%0d level=%0d want 0 0 %h 0 0",
                 ack, s_ready, dout, count, level, INIT);
      end
    end
    rst = 1'b0;
    cycle();
    n_vec++;
    if (ack !== 1'b0) begin n_err++; $display("FAIL reset_release_edge1: ack=%b want 0", ack); end
    s_valid = 1'b0;
    cycle();
    n_vec++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL reset_release_edge2: ack=%b want 1", ack); end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front(); m_dout = e;
      n_vec++;
      if (dout !== e) begin n_err++; $display("FAIL reset_first_word: dout=%h want %h", dout, e); end
    end
  endtask

  task automatic test_single_word();
    logic [DW-1:0] e;
    int acks = 0;
    apply_reset();
    s_valid = 1'b1; s_data = 32'h5;
    cycle();
    s_valid = 1'b0; req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_vec++;
      if (ack !== m_ack) begin n_err++; $display("FAIL single_ack: cyc=%0d ack=%b want %b", i, ack, m_ack); end
      if (ack === 1'b1) begin
        acks++;
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL single_dout: ack with no word, dout=%h", dout); end
        else begin
          e = exp_q.pop_front(); m_dout = e;
          if (dout !== e) begin n_err++; $display("FAIL single_dout: dout=%h want %h", dout, e); end
        end
      end
    end
    n_vec++;
    if (acks != 1) begin n_err++; $display("FAIL single_ack_count: acks=%0d want 1", acks); end
    n_vec++;
    if (count !== 32'd1) begin n_err++; $display("FAIL single_count: count=%0d want 1", count); end
    req = 1'b0;
  endtask

  task automatic test_order_full();
    logic [DW-1:0] e;
    int got = 0;
    int since = 2;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = DW'(i);
      cycle();
    end
    n_vec++;
    if (level !== 3'd4 || s_ready !== 1'b0) begin
      n_err++; $display("FAIL full_state: level=%0d s_ready=%b want 4 0", level, s_ready);
    end
    s_data = 32'd4;
    cycle();
    s_valid = 1'b0;
    n_vec++;
    if (level !== 3'(m_level)) begin n_err++; $display("FAIL full_refuse: level=%0d want %0d", level, m_level); end
    // Requester holds req one cycle past ack, drops it for a cycle, then re-raises.
    for (int g = 0; g < 40 && got < 4; g++) begin
      req = (since != 1);
      cycle();
      n_vec++;
      if (ack !== m_ack) begin n_err++; $display("FAIL order_ack: ack=%b want %b", ack, m_ack); end
      if (ack === 1'b1) begin
        got++;
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL order_dout: ack with no word, dout=%h", dout); end
        else begin
          e = exp_q.pop_front(); m_dout = e;
          if (dout !== e) begin n_err++; $display("FAIL order_dout: dout=%h want %h", dout, e); end
        end
        if (got == 1) begin
          n_vec++;
          if (s_ready !== 1'b1) begin n_err++; $display("FAIL order_ready_rise: s_ready=%b want 1", s_ready); end
        end
        since = 0;
      end else begin
        since++;
      end
    end
    n_vec++;
    if (got != 4) begin n_err++; $display("FAIL order_drain: acks=%0d want 4", got); end
    req = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] e;
    int pushed = 0;
    bit acc;
    apply_reset();
    s_valid = 1'b1; s_data = 32'hA0; cycle();
    s_data = 32'hA1; cycle();
    s_data = 32'hA2; req = 1'b1;
    cycle();
    n_vec++;
    if (level !== 3'd2 || ack !== 1'b1) begin
      n_err++; $display("FAIL simul_level: level=%0d ack=%b want 2 1", level, ack);
    end
    if (ack === 1'b1 && exp_q.size() != 0) begin
      e = exp_q.pop_front(); m_dout = e;
      n_vec++;
      if (dout !== e) begin n_err++; $display("FAIL simul_first: dout=%h want %h", dout, e); end
    end
    for (int g = 0; g < 10000 && (pushed < 1000 || exp_q.size() > 0); g++) begin
      s_valid = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      s_data  = $urandom;
      req     = ($urandom_range(0, 3) != 0);
      acc     = s_valid && (m_level != DEPTH);
      n_vec++;
      if (s_ready !== (m_level != DEPTH)) begin
        n_err++; $display("FAIL rand_ready: s_ready=%b level_model=%0d", s_ready, m_level);
      end
      cycle();
      if (acc) pushed++;
      n_vec++;
      if (ack !== m_ack || level !== 3'(m_level)) begin
        n_err++; $display("FAIL rand_ctl: ack=%b level=%0d want %b %0d", ack, level, m_ack, m_level);
      end
      if (ack === 1'b1) begin
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rand_dout: ack with no word, dout=%h", dout); end
        else begin e = exp_q.pop_front(); m_dout = e; end
      end
      n_vec++;
      if (dout !== m_dout) begin n_err++; $display("FAIL rand_dout: dout=%h want %h", dout, m_dout); end
    end
    n_vec++;
    if (pushed != 1000 || exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_complete: pushed=%0d pending=%0d want 1000 0", pushed, exp_q.size());
    end
    s_valid = 1'b0; req = 1'b0;
  endtask

  task automatic test_into_arf();
    logic [DW-1:0] e, y;
    int k = 0;
    int j = 0;
    bit acc;
    apply_reset();
    req = 1'b1;
    for (int g = 0; g < 20000 && j < 5000; g++) begin
      s_valid = (k < 5000);
      s_data  = DW'(k);
      acc     = s_valid && (m_level != DEPTH);
      cycle();
      if (acc) k++;
      if (ack !== m_ack) begin n_vec++; n_err++; $display("FAIL arf_ack: ack=%b want %b", ack, m_ack); end
      if (ack === 1'b1) begin
        if (exp_q.size() != 0) begin e = exp_q.pop_front(); m_dout = e; end
        y = dout + (dout + 32'd2) + dout;
        n_vec++;
        if (y !== DW'(3 * j + 2)) begin n_err++; $display("FAIL arf_out: i=%0d got %0d want %0d", j, y, 3 * j + 2); end
        j++;
      end
    end
    n_vec++;
    if (count !== 32'd5000 || j != 5000) begin
      n_err++; $display("FAIL arf_count: count=%0d consumed=%0d want 5000 5000", count, j);
    end
    s_valid = 1'b0; req = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = DW'(32'h10 + i);
      cycle();
    end
    s_data = 32'h13; req = 1'b1;
    cycle();
    n_vec++;
    if (ack !== 1'b1 || level !== 3'd3) begin
      n_err++; $display("FAIL midrst_setup: ack=%b level=%0d want 1 3", ack, level);
    end
    if (ack === 1'b1 && exp_q.size() != 0) begin e = exp_q.pop_front(); m_dout = e; end
    rst = 1'b1;
    cycle();
    n_vec++;
    if (ack !== 1'b0 || level !== 3'd0 || dout !== INIT) begin
      n_err++; $display("FAIL midrst_edge: ack=%b level=%0d dout=%h want 0 0 %h", ack, level, dout, INIT);
    end
    rst = 1'b0; s_data = 32'h55;
    cycle();
    n_vec++;
    if (ack !== 1'b0) begin n_err++; $display("FAIL midrst_after: ack=%b want 0", ack); end
    s_valid = 1'b0;
    cycle();
    n_vec++;
    if (ack !== 1'b1 || dout !== 32'h55) begin
      n_err++; $display("FAIL midrst_first_word: ack=%b dout=%h want 1 00000055", ack, dout);
    end
    if (ack === 1'b1 && exp_q.size() != 0) begin e = exp_q.pop_front(); m_dout = e; end
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; req = 1'b0; s_data = '0;
    test_reset();
    test_single_word();
    test_order_full();
    test_simultaneous();
    test_into_arf();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
